// File: rtl/md5_pkg.sv
// Shared MD5 types and constants.
// Used by the padder and the compression core.
package md5_pkg;

  localparam int         MD5_BLK_W    = 512;
  localparam int         MD5_WORDS    = 16;
  localparam logic [7:0] MD5_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    LEN,
    EMIT
  } md5_pad_st_t;

endpackage

// File: rtl/md5_last_word_pad.sv
// Final message word shaping: keep the valid bytes,
// drop the rest and insert the 0x80 marker byte.
module md5_last_word_pad
  import md5_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  nbytes_i,
  output logic [31:0] word_o,
  output logic        pad_done_o
);

  always_comb begin
    word_o     = data_i;
    pad_done_o = 1'b0;
    case (nbytes_i)
      3'd1: begin
        word_o     = {16'h0, MD5_PAD_BYTE, data_i[7:0]};
        pad_done_o = 1'b1;
      end
      3'd2: begin
        word_o     = {8'h0, MD5_PAD_BYTE, data_i[15:0]};
        pad_done_o = 1'b1;
      end
      3'd3: begin
        word_o     = {MD5_PAD_BYTE, data_i[23:0]};
        pad_done_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md5_padder.sv
// Packs a 32-bit word stream into RFC 1321 padded
// 512-bit blocks for the MD5 core.
module md5_padder
  import md5_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  in_data_i,
  input  logic         in_valid_i,
  input  logic         in_last_i,
  input  logic [2:0]   in_nbytes_i,
  output logic         in_ready_o,
  output logic [511:0] blk_o,
  output logic         blk_valid_o,
  input  logic         blk_ready_i,
  output logic         blk_last_o,
  output logic         busy_o
);

  md5_pad_st_t state_q, state_d;

  logic [31:0]      mem_q [MD5_WORDS];
  logic [3:0]       idx_q;
  logic [LEN_W-1:0] len_q;
  logic             pad_done_q;
  logic             msg_end_q;
  logic             last_q;
  logic             busy_q;

  logic        accept;
  logic        hs;
  logic        wr_top;
  logic        nz;
  logic [4:0]  free_w;
  logic [63:0] len64;
  logic [31:0] lw_word;
  logic        lw_pad;

  md5_last_word_pad u_lwp (
    .data_i     (in_data_i),
    .nbytes_i   (in_nbytes_i),
    .word_o     (lw_word),
    .pad_done_o (lw_pad)
  );

  assign in_ready_o  = (state_q == FILL);
  assign blk_valid_o = (state_q == EMIT);
  assign blk_last_o  = last_q;
  assign busy_o      = busy_q;

  assign accept = in_valid_i & in_ready_o;
  assign hs     = blk_valid_o & blk_ready_i;
  assign wr_top = (idx_q == 4'd15);
  assign nz     = (in_nbytes_i != 3'd0);
  assign free_w = {1'b0, idx_q} + {4'b0, ~pad_done_q};
  assign len64  = 64'(len_q);

  always_comb begin
    blk_o = '0;
    for (int m = 0; m < MD5_WORDS; m++) begin
      blk_o[511-32*m -: 32] = mem_q[m];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (in_last_i) begin
            state_d = (wr_top && nz) ? EMIT : PAD;
          end else if (wr_top) begin
            state_d = EMIT;
          end
        end
      end
      PAD: begin
        state_d = (free_w <= 5'd14) ? LEN : EMIT;
      end
      LEN: begin
        state_d = EMIT;
      end
      EMIT: begin
        if (hs) begin
          if (last_q) begin
            state_d = FILL;
          end else if (msg_end_q) begin
            state_d = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q      <= '0;
      len_q      <= '0;
      pad_done_q <= 1'b0;
      msg_end_q  <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      for (int m = 0; m < MD5_WORDS; m++) begin
        mem_q[m] <= '0;
      end
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            busy_q <= 1'b1;
            last_q <= 1'b0;
            if (!in_last_i) begin
              mem_q[idx_q] <= in_data_i;
              len_q        <= len_q + LEN_W'(32);
              idx_q        <= idx_q + 4'd1;
            end else begin
              if (nz) begin
                mem_q[idx_q] <= lw_word;
                idx_q        <= idx_q + 4'd1;
              end
              pad_done_q <= lw_pad;
              len_q      <= len_q + LEN_W'({in_nbytes_i, 3'b000});
              msg_end_q  <= 1'b1;
            end
          end
        end
        PAD: begin
          // free_w is idx+1 when the marker goes in now, so no overlap
          for (int m = 0; m < MD5_WORDS; m++) begin
            if (5'(m) >= free_w) begin
              mem_q[m] <= '0;
            end
          end
          if (!pad_done_q) begin
            mem_q[idx_q] <= {24'h0, MD5_PAD_BYTE};
          end
          pad_done_q <= 1'b1;
          last_q     <= 1'b0;
        end
        LEN: begin
          mem_q[14] <= len64[31:0];
          mem_q[15] <= len64[63:32];
          last_q    <= 1'b1;
        end
        EMIT: begin
          if (hs) begin
            idx_q <= '0;
            if (last_q) begin
              len_q      <= '0;
              pad_done_q <= 1'b0;
              msg_end_q  <= 1'b0;
              last_q     <= 1'b0;
              busy_q     <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_padder.sv
// Scoreboard bench for md5_padder: directed messages,
// back-pressure and mid-message reset.
module tb_md5_padder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [2:0]   in_nbytes = '0;
  logic         in_ready;
  logic [511:0] blk;
  logic         blk_valid;
  logic         blk_ready = 1'b1;
  logic         blk_last;
  logic         busy;

  md5_padder #(.LEN_W(64)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_last_i   (in_last),
    .in_nbytes_i (in_nbytes),
    .in_ready_o  (in_ready),
    .blk_o       (blk),
    .blk_valid_o (blk_valid),
    .blk_ready_i (blk_ready),
    .blk_last_o  (blk_last),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int hs_cnt = 0;

  logic [512:0] exp_q [$];
  logic [31:0]  ew [16];
  logic [511:0] abc_blk;

  task automatic chk(input string name, input logic [511:0] act,
                     input logic [511:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  function automatic logic [511:0] pack_ew();
    logic [511:0] b;
    b = '0;
    for (int m = 0; m < 16; m++) b[511-32*m -: 32] = ew[m];
    return b;
  endfunction

  task automatic clr_ew();
    for (int m = 0; m < 16; m++) ew[m] = '0;
  endtask

  task automatic push_exp(input logic last);
    exp_q.push_back({last, pack_ew()});
    clr_ew();
  endtask

  always @(negedge clk) begin
    logic [512:0] e;
    if (!rst && blk_valid && blk_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_blk: got %h want none", blk);
      end else begin
        e = exp_q.pop_front();
        chk("blk", blk, e[511:0]);
        chk("blk_last", 512'(blk_last), 512'(e[512]));
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l,
                      input logic [2:0] n);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout: in_ready %0b want 1", in_ready);
    end
    in_data   = d;
    in_valid  = 1'b1;
    in_last   = l;
    in_nbytes = n;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || blk_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (exp_q.size() == 0 && !blk_valid) passes++;
    else $display("FAIL drain_timeout: pending %0d want 0", exp_q.size());
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!blk_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("wait_valid", 512'(blk_valid), 512'(1));
  endtask

  initial begin
    int h0;
    clr_ew();
    ew[0] = 32'h80636261;
    ew[14] = 32'h18;
    abc_blk = pack_ew();
    clr_ew();

    repeat (2) @(negedge clk);
    chk("rst_valid", 512'(blk_valid), 512'(0));
    chk("rst_ready", 512'(in_ready), 512'(1));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_last", 512'(blk_last), 512'(0));
    chk("rst_blk", blk, 512'(0));
    rst = 1'b0;

    // "abc" with latency check
    ew[0] = 32'h80636261;
    ew[14] = 32'h18;
    push_exp(1'b1);
    send(32'h00636261, 1'b1, 3'd3);
    chk("lat_n0", 512'(blk_valid), 512'(0));
    @(posedge clk); #1;
    chk("lat_n1", 512'(blk_valid), 512'(0));
    chk("busy_mid", 512'(busy), 512'(1));
    @(posedge clk); #1;
    chk("lat_n2", 512'(blk_valid), 512'(1));
    drain();
    chk("busy_done", 512'(busy), 512'(0));

    // empty message
    ew[0] = 32'h80;
    push_exp(1'b1);
    send(32'hDEADBEEF, 1'b1, 3'd0);
    drain();

    // 56 bytes -> two blocks
    for (int k = 0; k < 14; k++) ew[k] = 32'hA5A50000 | k;
    ew[14] = 32'h80;
    push_exp(1'b0);
    ew[14] = 32'h1C0;
    push_exp(1'b1);
    for (int k = 0; k < 14; k++) send(32'hA5A50000 | k, k == 13, 3'd4);
    drain();

    // 64 bytes -> data block then pad/len block
    for (int k = 0; k < 16; k++) ew[k] = 32'h5A5A0000 | k;
    push_exp(1'b0);
    ew[0] = 32'h80;
    ew[14] = 32'h200;
    push_exp(1'b1);
    for (int k = 0; k < 16; k++) send(32'h5A5A0000 | k, k == 15, 3'd4);
    drain();

    // back-pressure
    blk_ready = 1'b0;
    ew[0] = 32'h80636261;
    ew[14] = 32'h18;
    push_exp(1'b1);
    send(32'h00636261, 1'b1, 3'd3);
    wait_valid();
    in_data  = 32'hFFFFFFFF;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_ready", 512'(in_ready), 512'(0));
      chk("bp_blk", blk, abc_blk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    h0 = hs_cnt;
    blk_ready = 1'b1;
    drain();
    chk("bp_hs", 512'(hs_cnt - h0), 512'(1));

    // reset mid-message, with a block pending
    blk_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(32'h11110000 | k, 1'b0, 3'd0);
    chk("rst5_busy", 512'(busy), 512'(1));
    for (int k = 5; k < 16; k++) send(32'h11110000 | k, 1'b0, 3'd0);
    wait_valid();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 512'(blk_valid), 512'(0));
    chk("arst_ready", 512'(in_ready), 512'(1));
    chk("arst_busy", 512'(busy), 512'(0));
    @(negedge clk);
    rst = 1'b0;
    blk_ready = 1'b1;
    ew[0] = 32'h80636261;
    ew[14] = 32'h18;
    push_exp(1'b1);
    send(32'h00636261, 1'b1, 3'd3);
    drain();

    chk("queue_empty", 512'(exp_q.size()), 512'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: time %0t want done", $time);
    $fatal(1, "timeout");
  end

endmodule
